// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, default byte width and the
// state encoding of the transmit arbiter.
package uart_pkg;

  // Baud-rate select codes understood by uart_byte_tx.
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Default byte width carried over the serial line.
  localparam int DATA_W = 8;

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker. Searches req starting
// one position after 'last' and wrapping at NUM_REQ; returns the first
// asserted index and a valid flag. Reusable by any scheduler that keeps a
// last-served pointer.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   last,
  output logic [OWN_W-1:0]   grant,
  output logic               valid
);

  // Index 'offs' positions after 'base', wrapped into 0..NUM_REQ-1.
  function automatic logic [OWN_W-1:0] wrap_idx(input logic [OWN_W-1:0] base,
                                                input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return OWN_W'(sum);
  endfunction

  // Scan from the farthest candidate back to the nearest so that the nearest
  // asserted request after 'last' is the one left standing.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // grant or valid unassigned would infer a latch.
    grant = last;
    valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_idx(last, k)]) begin
        grant = wrap_idx(last, k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_byte_tx between NUM_REQ byte producers.
// A round-robin grant latches the winner's byte, a one-cycle send_en launches
// it, and a done pulse returns to the owner once Tx_Done is seen.
// Optional build macro UART_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog and a
// 'timeout' output port.
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter int         DATA_W   = uart_pkg::DATA_W,
  parameter logic [2:0] BAUD_SEL = uart_pkg::BAUD_9600,
  parameter int         OWN_W    = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         tx_data_byte,
  output logic                      tx_send_en,
  output logic [2:0]                tx_baud_set,
  input  logic                      tx_done,
  input  logic                      tx_busy,
  output logic                      busy,
  output logic [OWN_W-1:0]          owner
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  import uart_pkg::*;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_CYC = 20'd1_000_000;
`endif

  arb_state_e          state_q,   state_d;
  logic [OWN_W-1:0]    owner_q,   owner_d;
  logic [OWN_W-1:0]    last_q,    last_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic                busy_q,    busy_d;
  logic                send_en_q, send_en_d;
  logic [NUM_REQ-1:0]  ack_q,     ack_d;
  logic [NUM_REQ-1:0]  done_q,    done_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic [19:0]         wd_q,      wd_d;
  logic                timeout_q, timeout_d;
`endif

  logic [OWN_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // Next-state and registered-output logic for the grant/launch/wait cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    data_d    = data_q;
    busy_d    = busy_q;
    send_en_d = 1'b0;
    ack_d     = '0;
    done_d    = '0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A transmitter still shifting a frame blocks any new grant.
        if (pick_valid && !tx_busy) begin
          owner_d = pick_idx;
          data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          busy_d  = 1'b1;
          state_d = LAUNCH;
        end
      end

      LAUNCH: begin
        send_en_d      = 1'b1;
        ack_d[owner_q] = 1'b1;
        last_d         = owner_q;
        state_d        = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        wd_d           = '0;
`endif
      end

      WAIT_DONE: begin
        if (tx_done) begin
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd_q == TIMEOUT_CYC - 20'd1) begin
          // Transmitter never answered: release the owner anyway.
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          timeout_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          wd_d = wd_q + 20'd1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight silently.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= OWN_W'(NUM_REQ - 1);
      data_q    <= '0;
      busy_q    <= 1'b0;
      send_en_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values of the previous cycle, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      send_en_q <= send_en_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign tx_data_byte = data_q;
  assign tx_send_en   = send_en_q;
  assign tx_baud_set  = BAUD_SEL;
  assign busy         = busy_q;
  assign owner        = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Producers are modelled as byte
// queues, the transmitter as a frame-length counter; a round-robin service
// model over the queues predicts every launch, and a monitor compares each
// launch and done pulse against the predictions.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int OWN_W   = 2;

  typedef logic [DATA_W-1:0] byte_q_t [$];
  typedef struct { int owner; logic [DATA_W-1:0] data; int due; } send_exp_t;
  typedef struct { int owner; int due; } done_exp_t;

  logic                      Clk = 1'b0;
  logic                      Rst = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        ack, done;
  logic [DATA_W-1:0]         tx_data_byte;
  logic                      tx_send_en;
  logic [2:0]                tx_baud_set;
  logic                      tx_done, tx_busy, busy;
  logic [OWN_W-1:0]          owner;
`ifdef UART_ARB_TIMEOUT_EN
  logic                      timeout;
`endif

  logic uart_done = 1'b0, spur_done = 1'b0, uart_busy = 1'b0, force_busy = 1'b0;
  assign tx_done = uart_done | spur_done;
  assign tx_busy = uart_busy | force_busy;

  int n_vec = 0, n_err = 0, cyc = 0, n_sent = 0;
  int frame_len = 10, uart_rem = 0, inflight_owner = 0, model_last = NUM_REQ - 1;
  logic [DATA_W-1:0] inflight_byte = '0;
  byte_q_t   pend [NUM_REQ];
  send_exp_t send_q[$];
  done_exp_t done_q[$];

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .BAUD_SEL (3'd0),
    .OWN_W    (OWN_W)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .done         (done),
    .tx_data_byte (tx_data_byte),
    .tx_send_en   (tx_send_en),
    .tx_baud_set  (tx_baud_set),
    .tx_done      (tx_done),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .owner        (owner)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input int info);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event, info %0d (cycle %0d)", name, info, cyc);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: serve the queued bytes one at a time, always taking the
  // first non-empty producer after the one served last.
  task automatic predict_batch(input int first_due);
    int taken [NUM_REQ];
    int left, c;
    bit first;
    left  = 0;
    first = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      taken[i] = 0;
      left += pend[i].size();
    end
    while (left > 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (model_last + k) % NUM_REQ;
        if (taken[c] < pend[c].size()) begin
          send_q.push_back('{owner: c, data: pend[c][taken[c]], due: (first ? first_due : -1)});
          taken[c]++;
          left--;
          model_last = c;
          first = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      tick();
      if (send_q.size() == 0 && done_q.size() == 0 && !busy && uart_rem == 0 &&
          !uart_busy && !uart_done && pend[0].size() == 0 && pend[1].size() == 0 &&
          pend[2].size() == 0 && pend[3].size() == 0) break;
      n++;
    end
    if (n >= budget) begin
      fail_evt("drain_timeout", send_q.size());
      send_q.delete();
      done_q.delete();
      for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    end
  endtask

  task automatic wait_send(input int snap, input int budget);
    int n;
    n = 0;
    while (n_sent == snap && n < budget) begin
      tick();
      n++;
    end
    if (n_sent == snap) fail_evt("send_timeout", snap);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    send_q.delete();
    done_q.delete();
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    repeat (3) tick();
    Rst = 1'b0;
    model_last = NUM_REQ - 1;
    tick();
  endtask

  // Producers: hold req with the head byte until acknowledged.
  always begin
    @(posedge Clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      req[i] = (pend[i].size() > 0);
      req_data[i*DATA_W +: DATA_W] = (pend[i].size() > 0) ? pend[i][0] : '0;
    end
  end

  // Transmitter model: busy for frame_len cycles after send_en, then Tx_Done.
  always begin
    @(posedge Clk);
    #1;
    if (Rst) begin
      uart_rem  = 0;
      uart_busy = 1'b0;
      uart_done = 1'b0;
    end else begin
      if (uart_done) begin
        uart_done = 1'b0;
        uart_busy = 1'b0;
      end
      if (uart_rem > 0) begin
        uart_rem--;
        if (uart_rem == 0) begin
          uart_done = 1'b1;
          check("frame_data_hold", tx_data_byte, inflight_byte);
          done_q.push_back('{owner: inflight_owner, due: cyc + 1});
        end
      end
      if (tx_send_en) begin
        uart_busy = 1'b1;
        uart_rem  = frame_len;
      end
    end
  end

  // Monitor: compare every launch and done pulse with the predictions.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (tx_send_en) begin
        if (send_q.size() == 0) begin
          fail_evt("unexpected_send", int'(owner));
        end else begin
          send_exp_t e;
          e = send_q.pop_front();
          check("send_byte", tx_data_byte, e.data);
          check("send_ack", ack, 32'(1) << e.owner);
          check("send_owner", owner, e.owner);
          check("send_busy", busy, 1);
          if (e.due >= 0) check("send_latency", cyc, e.due);
          inflight_owner = e.owner;
          inflight_byte  = e.data;
        end
        n_sent++;
      end else if (ack != '0) begin
        check("stray_ack", ack, 0);
      end
      if (done != '0) begin
        if (done_q.size() == 0) begin
          check("stray_done", done, 0);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_onehot", done, 32'(1) << d.owner);
          check("done_latency", cyc, d.due);
          check("done_busy_low", busy, 0);
        end
      end else if (done_q.size() > 0 && done_q[0].due < cyc) begin
        fail_evt("done_missing", done_q[0].owner);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int snap;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_send_en", tx_send_en, 0);
    check("rst_data", tx_data_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("baud_set", tx_baud_set, 0);

    // Single producer, 100-cycle frame.
    tick();
    frame_len = 100;
    pend[0].push_back(8'h9D);
    predict_batch(cyc + 2);
    wait_drain(400);

    // All four producers; rotation from a fresh pointer.
    do_reset();
    frame_len = 20;
    pend[0].push_back(8'h11);
    pend[0].push_back(8'h11);
    pend[1].push_back(8'h22);
    pend[2].push_back(8'h33);
    pend[3].push_back(8'h44);
    predict_batch(cyc + 2);
    wait_drain(400);

    // Transmitter busy blocks the grant; release gives it two cycles later.
    force_busy = 1'b1;
    pend[2].push_back(8'h5A);
    snap = n_sent;
    repeat (8) tick();
    check("busy_hold_no_send", n_sent, snap);
    check("busy_hold_idle", busy, 0);
    force_busy = 1'b0;
    predict_batch(cyc + 2);
    wait_drain(200);

    // Spurious Tx_Done while idle is ignored; normal service continues.
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    @(negedge Clk);
    check("spur_no_done", done, 0);
    check("spur_not_busy", busy, 0);
    tick();
    pend[1].push_back(8'hC7);
    predict_batch(cyc + 2);
    wait_drain(200);

    // A request raised and dropped during someone else's frame is never served.
    frame_len = 60;
    snap = n_sent;
    pend[0].push_back(8'hC3);
    predict_batch(cyc + 2);
    wait_send(snap, 20);
    repeat (5) tick();
    pend[3].push_back(8'hEE);
    repeat (20) tick();
    pend[3].delete();
    wait_drain(200);
    repeat (10) tick();
    check("dropped_req_not_served", n_sent, snap + 1);

    // Reset mid-frame: outputs clear at once, no done, pointer restarts.
    frame_len = 500;
    snap = n_sent;
    pend[1].push_back(8'h77);
    predict_batch(cyc + 2);
    wait_send(snap, 20);
    repeat (5) tick();
    Rst = 1'b1;
    send_q.delete();
    done_q.delete();
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_done", done, 0);
    check("midrst_send_en", tx_send_en, 0);
    check("midrst_data", tx_data_byte, 0);
    check("midrst_busy", busy, 0);
    check("midrst_owner", owner, 0);
    repeat (3) tick();
    Rst = 1'b0;
    model_last = NUM_REQ - 1;
    tick();
    frame_len = 15;
    pend[0].push_back(8'hA5);
    pend[1].push_back(8'h5B);
    predict_batch(cyc + 2);
    wait_drain(200);

    // Randomized batches of queued bytes and frame lengths.
    for (int b = 0; b < 25; b++) begin
      int mask;
      mask = $urandom_range(1, 15);
      frame_len = $urandom_range(1, 30);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (mask[i]) begin
          int cnt;
          cnt = $urandom_range(1, 3);
          for (int j = 0; j < cnt; j++) pend[i].push_back(DATA_W'($urandom));
        end
      end
      predict_batch(cyc + 2);
      wait_drain(1000);
    end

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
